// File: rtl/transmissor_imagem_serial.sv
// Image buffer to UART 8N1 transmitter: sends header, N buffer bytes read in
// row-major order, then an 8-bit additive checksum, as one framed packet.
module transmissor_imagem_serial #(
  parameter int          LINHAS    = 4,
  parameter int          COLUNAS   = 4,
  parameter int          DIV_BAUD  = 434,
  parameter logic [7:0]  CABECALHO = 8'hA5,
  parameter int          AW        = $clog2(LINHAS * COLUNAS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic [7:0]    dado_mem,
  output logic [AW-1:0] endereco_mem,
  output logic          re_mem,
  output logic          saida_serial,
  output logic          ocupado,
  output logic          pronto,
  output logic [3:0]    db_estado
);

  localparam int N  = LINHAS * COLUNAS;
  localparam int BW = $clog2(DIV_BAUD);

  localparam logic [AW-1:0] ULTIMO_END = AW'(N - 1);
  localparam logic [BW-1:0] BAUD_MAX   = BW'(DIV_BAUD - 1);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARACAO     = 4'd1,
    TRANSMITE      = 4'd2,
    LE_BYTE        = 4'd3,
    CARREGA        = 4'd4,
    PROXIMO        = 4'd5,
    ENVIA_CHECKSUM = 4'd6,
    FINAL          = 4'd7
  } estado_t;

  typedef enum logic [1:0] {
    T_CABECALHO = 2'd0,
    T_DADO      = 2'd1,
    T_CHECKSUM  = 2'd2
  } tipo_t;

  estado_t       estado;
  tipo_t         tipo;
  logic [7:0]    tx_byte;
  logic [7:0]    checksum;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;

  // Handshake: re_mem is a one-cycle read strobe at endereco_mem; the memory
  // returns dado_mem on the following cycle (state carrega), where it is taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= INICIAL;
      tipo         <= T_CABECALHO;
      tx_byte      <= 8'h00;
      checksum     <= 8'h00;
      baud_cnt     <= '0;
      bit_cnt      <= 4'd0;
      endereco_mem <= '0;
      re_mem       <= 1'b0;
      saida_serial <= 1'b1;
      ocupado      <= 1'b0;
      pronto       <= 1'b0;
    end else begin
      re_mem <= 1'b0;
      pronto <= 1'b0;
      case (estado)
        INICIAL: begin
          if (iniciar) begin
            estado  <= PREPARACAO;
            ocupado <= 1'b1;
          end
        end

        PREPARACAO: begin
          endereco_mem <= '0;
          checksum     <= 8'h00;
          tipo         <= T_CABECALHO;
          tx_byte      <= CABECALHO;
          saida_serial <= 1'b0;
          baud_cnt     <= '0;
          bit_cnt      <= 4'd0;
          estado       <= TRANSMITE;
        end

        // bit_cnt 0 is the start bit, 1..8 data LSB first, 9 the stop bit
        TRANSMITE: begin
          if (baud_cnt == BAUD_MAX) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              saida_serial <= 1'b1;
              case (tipo)
                T_CABECALHO: begin
                  estado <= LE_BYTE;
                  re_mem <= 1'b1;
                end
                T_DADO: begin
                  if (endereco_mem == ULTIMO_END) estado <= ENVIA_CHECKSUM;
                  else                            estado <= PROXIMO;
                end
                default: begin
                  estado <= FINAL;
                  pronto <= 1'b1;
                end
              endcase
            end else begin
              bit_cnt      <= bit_cnt + 4'd1;
              saida_serial <= (bit_cnt == 4'd8) ? 1'b1 : tx_byte[bit_cnt[2:0]];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        PROXIMO: begin
          endereco_mem <= endereco_mem + 1'b1;
          re_mem       <= 1'b1;
          estado       <= LE_BYTE;
        end

        LE_BYTE: begin
          estado <= CARREGA;
        end

        CARREGA: begin
          tx_byte      <= dado_mem;
          checksum     <= checksum + dado_mem;
          tipo         <= T_DADO;
          saida_serial <= 1'b0;
          baud_cnt     <= '0;
          bit_cnt      <= 4'd0;
          estado       <= TRANSMITE;
        end

        ENVIA_CHECKSUM: begin
          tx_byte      <= checksum;
          tipo         <= T_CHECKSUM;
          saida_serial <= 1'b0;
          baud_cnt     <= '0;
          bit_cnt      <= 4'd0;
          estado       <= TRANSMITE;
        end

        FINAL: begin
          estado  <= INICIAL;
          ocupado <= 1'b0;
        end

        default: begin
          estado       <= INICIAL;
          ocupado      <= 1'b0;
          saida_serial <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    db_estado = 4'b1111;
    case (estado)
      INICIAL, PREPARACAO, TRANSMITE, LE_BYTE,
      CARREGA, PROXIMO, ENVIA_CHECKSUM, FINAL: db_estado = estado;
      default:                                 db_estado = 4'b1111;
    endcase
  end

endmodule

// File: tb/tb_transmissor_imagem_serial.sv
// Directed bench for transmissor_imagem_serial: 2x2 buffer, 4 cycles per bit,
// UART line decoder, memory model with garbage outside the valid read cycle.
module tb_transmissor_imagem_serial;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [7:0] dado_mem;
  logic [1:0] endereco_mem;
  logic       re_mem, saida_serial, ocupado, pronto;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  transmissor_imagem_serial #(
    .LINHAS(2), .COLUNAS(2), .DIV_BAUD(4), .CABECALHO(8'hA5)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .dado_mem(dado_mem),
    .endereco_mem(endereco_mem), .re_mem(re_mem), .saida_serial(saida_serial),
    .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
  );

  // synchronous memory; data bus carries random garbage except right after a read
  logic [7:0] mem [4];
  logic [7:0] mem_q = 8'h00;
  logic [7:0] lixo  = 8'h00;
  logic       rd_valid = 1'b0;
  always @(posedge clock) begin
    rd_valid <= re_mem;
    if (re_mem) mem_q <= mem[endereco_mem];
    lixo <= 8'($urandom);
  end
  assign dado_mem = rd_valid ? mem_q : lixo;

  // line / bus monitor, sampled on the falling edge
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         re_addr_q[$];
  int         pronto_cnt = 0, pronto_cyc = 0, glitch = 0, frame_err = 0;
  bit         in_byte = 1'b0;
  int         bcyc = 0;
  logic       cur_bit = 1'b1;
  logic [7:0] shreg = 8'h00;

  always @(negedge clock) begin
    if (!reset) begin
      in_byte = 1'b0;
    end else begin
      if (pronto) begin
        pronto_cnt++;
        pronto_cyc = cyc;
      end
      if (re_mem) re_addr_q.push_back(int'(endereco_mem));
      if (!in_byte) begin
        if (saida_serial == 1'b0) begin
          in_byte = 1'b1;
          bcyc    = 0;
          shreg   = 8'h00;
          start_q.push_back(cyc);
        end
      end else begin
        bcyc++;
      end
      if (in_byte) begin
        if (bcyc % 4 == 0) begin
          cur_bit = saida_serial;
          if (bcyc / 4 >= 1 && bcyc / 4 <= 8) shreg[bcyc / 4 - 1] = saida_serial;
        end else if (saida_serial !== cur_bit) begin
          glitch++;
        end
        if (bcyc == 39) begin
          in_byte = 1'b0;
          if (cur_bit !== 1'b1) frame_err++;
          rx_q.push_back(shreg);
        end
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int at_or(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_mon();
    @(posedge clock);
    rx_q.delete();
    start_q.delete();
    re_addr_q.delete();
    pronto_cnt = 0;
    glitch     = 0;
    frame_err  = 0;
  endtask

  task automatic pulse_iniciar(output int t);
    @(negedge clock);
    iniciar = 1'b1;
    t = cyc;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic wait_pronto(input int n, input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clock);
      if (pronto_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("pronto_timeout", pronto_cnt, n);
  endtask

  task automatic check_frame(input string tag, input int base,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3,
                             input logic [7:0] ck);
    logic [7:0] exp_b [6];
    exp_b[0] = 8'hA5; exp_b[1] = d0; exp_b[2] = d1;
    exp_b[3] = d2;    exp_b[4] = d3; exp_b[5] = ck;
    if (rx_q.size() < base + 6) begin
      check({tag, "_nbytes"}, rx_q.size(), base + 6);
      return;
    end
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_byte%0d", tag, i), int'(rx_q[base + i]), int'(exp_b[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, p1;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;

    // reset state
    repeat (3) @(negedge clock);
    check("rst_saida", saida_serial, 1);
    check("rst_ocupado", ocupado, 0);
    check("rst_pronto", pronto, 0);
    check("rst_re_mem", re_mem, 0);
    check("rst_endereco", endereco_mem, 0);
    check("rst_estado", db_estado, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // basic frame: A5 01 02 03 04 0A
    clear_mon();
    pulse_iniciar(t);
    wait_pronto(1, 400);
    check("t1_pronto_lat", pronto_cyc - t, 254);
    repeat (5) @(posedge clock);
    check_frame("t1", 0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
    check("t1_hdr_start", at_or(start_q, 0) - t, 2);
    check("t1_gap_hdr", at_or(start_q, 1) - at_or(start_q, 0) - 40, 2);
    check("t1_gap_data", at_or(start_q, 2) - at_or(start_q, 1) - 40, 3);
    check("t1_gap_chk", at_or(start_q, 5) - at_or(start_q, 4) - 40, 1);
    check("t1_glitch", glitch, 0);
    check("t1_frame_err", frame_err, 0);
    check("t1_pronto_cnt", pronto_cnt, 1);
    check("t1_nreads", re_addr_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_read_addr%0d", i), at_or(re_addr_q, i), i);
    check("t1_idle_estado", db_estado, 0);
    check("t1_idle_ocupado", ocupado, 0);

    // checksum wrap, plus iniciar pulsed mid-header
    mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'hFF; mem[3] = 8'h02;
    clear_mon();
    pulse_iniciar(t);
    repeat (12) @(negedge clock);
    check("t2_busy_estado", db_estado, 2);
    pulse_iniciar(p1);
    wait_pronto(1, 400);
    repeat (300) @(posedge clock);
    check_frame("t2", 0, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'hFF);
    check("t2_nbytes", rx_q.size(), 6);
    check("t2_pronto_cnt", pronto_cnt, 1);
    check("t2_glitch", glitch, 0);

    // reset during second data byte, then a clean frame
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
    clear_mon();
    pulse_iniciar(t);
    for (int i = 0; i < 300 && start_q.size() < 3; i++) @(posedge clock);
    check("t3_reached_byte2", start_q.size() >= 3, 1);
    repeat (6) @(negedge clock);
    check("t3_line_low_pre", saida_serial, 0);
    reset = 1'b0;
    #1;
    check("t3_async_saida", saida_serial, 1);
    check("t3_async_estado", db_estado, 0);
    check("t3_async_ocupado", ocupado, 0);
    repeat (3) @(negedge clock);
    check("t3_no_pronto", pronto_cnt, 0);
    reset = 1'b1;
    clear_mon();
    repeat (20) @(posedge clock);
    check("t3_stays_idle", rx_q.size() + start_q.size(), 0);
    pulse_iniciar(t);
    wait_pronto(1, 400);
    repeat (5) @(posedge clock);
    check_frame("t3", 0, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0);
    check("t3_first_addr", at_or(re_addr_q, 0), 0);
    check("t3_nreads", re_addr_q.size(), 4);
    check("t3_pronto_lat", pronto_cyc - t, 254);

    // back-to-back frames with iniciar held high
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    clear_mon();
    @(negedge clock);
    iniciar = 1'b1;
    wait_pronto(1, 400);
    p1 = pronto_cyc;
    repeat (10) @(negedge clock);
    iniciar = 1'b0;
    wait_pronto(2, 400);
    repeat (5) @(posedge clock);
    check("t4_nbytes", rx_q.size(), 12);
    check_frame("t4a", 0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
    check_frame("t4b", 6, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
    check("t4_restart_gap", at_or(start_q, 6) - p1, 3);
    check("t4_pronto_cnt", pronto_cnt, 2);
    check("t4_nreads", re_addr_q.size(), 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transmissor_imagem_serial.md
# transmissor_imagem_serial

Reads a captured image buffer byte by byte through a synchronous memory read port and transmits it over a UART 8N1 line as one framed packet: header, then data bytes, then checksum. It is the outbound path of the OV7670 interface. It sits after the quadrant buffer that the receive control unit fills, and it sends the stored image to the host/robot controller. It includes its own baud-rate generator and bit serializer, and exposes state for debug displays.

## Interface
- LINHAS, default 4: rows in the buffer.
- COLUNAS, default 4: columns in the buffer. N = LINHAS*COLUNAS bytes per frame, N ≥ 2.
- DIV_BAUD, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- CABECALHO, default 8'hA5: header byte sent first.
- AW, default $clog2(N): memory address width.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state is cleared while low.
- iniciar  in  1  start request, sampled in state inicial only.
- dado_mem  in  8  memory read data, valid the cycle after re_mem is high.
- endereco_mem  out  AW  read address, row-major (linha*COLUNAS + coluna).
- re_mem  out  1  memory read enable, one-cycle pulse.
- saida_serial  out  1  UART TX line; idles high.
- ocupado  out  1  high in every state except inicial.
- pronto  out  1  one-cycle pulse when the frame is complete.
- db_estado  out  4  encoding of the current state.

## Operation
- FSM states (db_estado):
  - inicial=0
  - preparacao=1
  - transmite=2
  - le_byte=3
  - carrega=4
  - proximo=5
  - envia_checksum=6
  - final=7
  - any illegal encoding shows 4'b1111 and goes to inicial.
- Transitions:
  - inicial → preparacao when iniciar=1.
  - preparacao → transmite. Clears the address and checksum, loads CABECALHO, sets the byte type to header.
  - transmite holds until the stop bit completes, then:
    - type header → le_byte;
    - type data and address = N-1 → envia_checksum;
    - type data otherwise → proximo;
    - type checksum → final.
  - proximo → le_byte. Increments endereco_mem.
  - le_byte → carrega. Asserts re_mem at the current address.
  - carrega → transmite. Latches dado_mem into the TX register, adds it to the checksum, sets type data.
  - envia_checksum → transmite. Loads the checksum, sets type checksum.
  - final → inicial. Asserts pronto.
- Checksum is the sum of the N data bytes modulo 256 (8-bit wrap). The header is excluded.
- Serializer:
  - Sends a 10-bit frame: start 0, data bits LSB first, stop 1.
  - Each bit lasts exactly DIV_BAUD cycles.
  - The baud counter and bit counter reset on every byte load.
- saida_serial is registered. It is 1 in all states except transmite.
- iniciar is ignored while ocupado=1; it does not queue.
- The address counter never wraps within a frame. The last byte read is at N-1.

## Timing
- Reset values: saida_serial=1, ocupado=0, pronto=0, re_mem=0, endereco_mem=0, db_estado=0. Checksum and counters are 0.
- Reset asserted mid-frame: the line returns high immediately (asynchronously). The frame is abandoned and no pronto is generated.
- iniciar high at edge T: preparacao occupies cycle T+1. The start bit of the header is on the line from T+2.
- Each byte occupies exactly 10*DIV_BAUD cycles on the line.
- Idle-high gap between a stop bit and the next start bit:
  - header→first data: 2 cycles;
  - data→data: 3 cycles;
  - last data→checksum: 1 cycle.
- re_mem is high for exactly 1 cycle per data byte. There are N pulses per frame, at addresses 0..N-1 in order. dado_mem is sampled in the following cycle (carrega).
- pronto is high for the single cycle after the checksum stop bit ends. The FSM is in inicial the cycle after that.
- Total cycles, iniciar edge to pronto: 1 + (N+2)*10*DIV_BAUD + 2 + 3*(N-1) + 1 + 1.
- iniciar held high continuously: a new frame starts in the cycle after returning to inicial.

## Test plan
- Basic frame. LINHAS=COLUNAS=2, DIV_BAUD=4, memory 01,02,03,04, pulse iniciar.
  - Line decodes A5,01,02,03,04,0A.
  - Every bit is exactly 4 cycles.
  - pronto fires once, at cycle 1+6*40+2+9+1+1=254 after iniciar.
- Checksum wrap. Memory FF,FF,FF,02 → checksum byte 8'hFF ((3*255+2) mod 256).
- Memory protocol. Check re_mem pulses at addresses 0,1,2,3, each 1 cycle wide. Corrupt dado_mem in every cycle except the one after re_mem → transmitted data is unaffected.
- iniciar during transmission. Pulse iniciar mid-header → no effect on the frame, exactly one pronto, no second frame.
- Reset mid-byte. Assert reset low during data byte 2.
  - saida_serial=1 and db_estado=0 immediately; pronto stays 0.
  - After release and a new iniciar, a full correct frame is sent starting from address 0.
- Back-to-back. Hold iniciar high → two consecutive complete frames. The header start bit of frame 2 begins 3 cycles after pronto of frame 1 (final → inicial → preparacao → transmite).
